// File: rtl/psubsb_seq.sv
// psubsb_seq: multi-cycle saturating parallel sub-word subtractor (PSUBSB).
// Splits the 16-bit operands into four signed 4-bit lanes and computes the
// saturated difference A-B one lane per clock. A valid/ready handshake is used
// on both the operand side and the result side. A per-lane saturation mask is
// returned together with the result.
module psubsb_seq #(
  parameter int LANE_W = 4,  // bits per lane; only 4 is supported
  parameter int LANES  = 4   // lanes per word; LANE_W*LANES must be 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   A,
  input  logic [LANE_W*LANES-1:0]   B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   RES,
  output logic [LANES-1:0]          sat_mask
);

  localparam int DATA_W     = LANE_W * LANES;
  localparam int LANE_CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);
  localparam logic [LANE_W-1:0]     SAT_POS   = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0]     SAT_NEG   = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LANE_CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
  logic [DATA_W-1:0]       a_q, a_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic [LANES-1:0]        sat_q, sat_d;

  // Operand acceptance happens whenever the upstream handshake completes.
  logic                    accept;

  // Current-lane operands, extended difference and saturated lane result.
  logic [LANE_W-1:0]       lane_a;
  logic [LANE_W-1:0]       lane_b;
  logic [LANE_W:0]         lane_diff;
  logic                    lane_ovf;
  logic [LANE_W-1:0]       lane_res;

  assign accept = in_valid & in_ready;

  // State and datapath registers, all cleared by the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  // The operand and result registers are reset as well, so an operation
  // interrupted by reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      sat_q      <= sat_d;
    end
  end

  // Next-state logic: IDLE -> CALC on accept, CALC -> DONE after the last
  // lane, DONE -> IDLE or straight back to CALC once the result is taken.
  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (lane_cnt_q == LAST_LANE) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the active lane from the latched operands using a constant-index mux.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_cnt_q == LANE_CNT_W'(i)) begin
        lane_a = a_q[i*LANE_W +: LANE_W];
        lane_b = b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  // Sign-extend both lane operands by one bit and subtract. A mismatch between
  // the two top bits of the difference means the true result does not fit in
  // LANE_W signed bits, and the sign bit then tells which rail to clamp to.
  always_comb begin
    lane_diff = {lane_a[LANE_W-1], lane_a} - {lane_b[LANE_W-1], lane_b};
    lane_ovf  = lane_diff[LANE_W] ^ lane_diff[LANE_W-1];
    if (lane_ovf) begin
      lane_res = lane_diff[LANE_W] ? SAT_NEG : SAT_POS;
    end else begin
      lane_res = lane_diff[LANE_W-1:0];
    end
  end

  // Datapath next state: latch operands and clear the result on accept,
  // otherwise fill in one lane per CALC cycle. The lane counter runs past the
  // last lane back to zero, which only happens on the CALC -> DONE step.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    sat_d      = sat_q;
    lane_cnt_d = lane_cnt_q;
    if (accept) begin
      a_d        = A;
      b_d        = B;
      res_d      = '0;
      sat_d      = '0;
      lane_cnt_d = '0;
    end else if (state_q == CALC) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_cnt_q == LANE_CNT_W'(i)) begin
          res_d[i*LANE_W +: LANE_W] = lane_res;
          sat_d[i]                  = lane_ovf;
        end
      end
      lane_cnt_d = lane_cnt_q + 1'b1;
    end
  end

  // Handshake outputs. The result is only exposed in DONE, so partially
  // computed lanes never reach the consumer.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    RES       = out_valid ? res_q : '0;
    sat_mask  = out_valid ? sat_q : '0;
  end

endmodule

// File: tb/tb_psubsb_seq.sv
// tb_psubsb_seq: randomized self-checking bench for psubsb_seq with a
// lane-by-lane integer reference model and directed corner cases.
module tb_psubsb_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] RES;
  logic [3:0]  sat_mask;

  int checks;
  int failures;

  psubsb_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RES       (RES),
    .sat_mask  (sat_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: per-lane signed integer subtraction, clamped to [-8, 7].
  // Returns {sat_mask, RES}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  m;
    logic [3:0]  la;
    logic [3:0]  lb;
    int          sa;
    int          sb;
    int          d;
    r = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      la = a[i*4 +: 4];
      lb = b[i*4 +: 4];
      sa = $signed(la);
      sb = $signed(lb);
      d  = sa - sb;
      if (d > 7) begin
        r[i*4 +: 4] = 4'h7;
        m[i]        = 1'b1;
      end else if (d < -8) begin
        r[i*4 +: 4] = 4'h8;
        m[i]        = 1'b1;
      end else begin
        r[i*4 +: 4] = 4'(d);
      end
    end
    return {m, r};
  endfunction

  // Present operands and take one accepting edge; scramble A/B afterwards so
  // the DUT must work from its latched copy.
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    #1;
    check("accept_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 16'($urandom);
    B         = 16'($urandom);
  endtask

  // Count clocks from the accepting edge to out_valid and check the result.
  // With noise set, in_valid/out_ready toggle randomly during CALC and must
  // have no effect.
  task automatic wait_result(input logic [15:0] a, input logic [15:0] b, input bit noise);
    logic [19:0] exp;
    int          lat;
    exp = model(a, b);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        A         = 16'($urandom);
        B         = 16'($urandom);
        #1;
        check("calc_in_ready_low", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 32'(lat), 32'd4);
    check("res", 32'(RES), 32'(exp[15:0]));
    check("sat_mask", 32'(sat_mask), 32'(exp[19:16]));
  endtask

  // Hold out_ready low for some cycles and verify the result stays put.
  task automatic hold_result(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [19:0] exp;
    exp = model(a, b);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_res", 32'(RES), 32'(exp[15:0]));
      check("hold_sat", 32'(sat_mask), 32'(exp[19:16]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
  endtask

  // Take the result without offering new operands; DUT returns to IDLE.
  task automatic release_result();
    out_ready = 1'b1;
    #1;
    check("done_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    accept_op(a, b);
    wait_result(a, b, 1'b0);
    hold_result(a, b, hold);
    release_result();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pa;
    logic [15:0] pb;
    logic [15:0] na;
    logic [15:0] nb;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(RES), 32'd0);
    check("rst_sat", 32'(sat_mask), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: plain, positive saturation, all-negative saturation,
    // mixed lanes with no cross-lane borrow.
    run_op(16'h1234, 16'h1111, 1);
    check("t1_model_res", 32'(model(16'h1234, 16'h1111)), 32'h0_0123);
    run_op(16'h7000, 16'h8000, 0);
    check("t2_model", 32'(model(16'h7000, 16'h8000)), 32'h8_7000);
    run_op(16'h8888, 16'h1111, 0);
    check("t3_model", 32'(model(16'h8888, 16'h1111)), 32'hF_8888);
    run_op(16'h7F0F, 16'hF17F, 0);
    check("t4_model", 32'(model(16'h7F0F, 16'hF17F)), 32'h8_7E90);

    // Stall in DONE for 3 cycles, then back-to-back accept with in_valid noise
    // during the second computation.
    accept_op(16'h1234, 16'h1111);
    wait_result(16'h1234, 16'h1111, 1'b0);
    hold_result(16'h1234, 16'h1111, 3);
    out_ready = 1'b1;
    accept_op(16'h7F0F, 16'hF17F);
    wait_result(16'h7F0F, 16'hF17F, 1'b1);
    release_result();

    // Reset while lane_cnt is 2: outputs must clear without waiting for a clock.
    accept_op(16'h8888, 16'h1111);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", 32'(RES), 32'd0);
    check("mid_rst_sat", 32'(sat_mask), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    run_op(16'h1234, 16'h1111, 0);

    // Reset while DONE is waiting on out_ready.
    accept_op(16'h7000, 16'h8000);
    wait_result(16'h7000, 16'h8000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", 32'(out_valid), 32'd0);
    check("done_rst_res", 32'(RES), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized operations, mixing stalls, back-to-back acceptance and noise.
    pa = 16'($urandom);
    pb = 16'($urandom);
    accept_op(pa, pb);
    wait_result(pa, pb, 1'b0);
    for (int i = 0; i < 60; i++) begin
      hold_result(pa, pb, int'($urandom_range(0, 3)));
      na = 16'($urandom);
      nb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
      end else begin
        release_result();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      accept_op(na, nb);
      wait_result(na, nb, 1'($urandom));
      pa = na;
      pb = nb;
    end
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
